vred_sequencer: RTL and testbench
=================================

VRED_SEQUENCER -- requirements
Module: vred_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 64, width of the beat, accumulator and result.
REQ-002 SHALL have parameters: SEW_WIDTH, default 2, element-width code width; OPSEL_WIDTH, default 9, opcode width.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset; one clock domain only.
REQ-004 SHALL have ports: start in 1, begin reduction; start_empty in 1, vector length zero; busy out 1, not IDLE.
REQ-005 SHALL have ports: sew in SEW_WIDTH (0=8b,1=16b,2=32b,3=64b); opSel in OPSEL_WIDTH; scalar in DATA_WIDTH, initial element in lane 0.
REQ-006 SHALL have ports: in_valid in 1; in_ready out 1; in_data in DATA_WIDTH, packed element lanes; in_last in 1, final beat.
REQ-007 SHALL have ports: red_vec0 out 2*DATA_WIDTH, {operand B, operand A}; red_en out 1; red_sew out SEW_WIDTH; red_opsel out OPSEL_WIDTH; red_out in DATA_WIDTH, lane-wise result one cycle after red_en.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_data out DATA_WIDTH, lane 0 result zero-extended.

Function
REQ-009 SHALL sequence the FSM IDLE -> ACCUM -> (ISSUE <-> CAPTURE per step) -> FOLD steps -> SCALAR step -> DONE -> IDLE.
REQ-010 SHALL, in IDLE on start=1, latch sew, opSel and scalar, load acc with the identity replicated per lane, and enter ACCUM; start is ignored outside IDLE.
REQ-011 SHALL use identities: sum 0; signed min 0x7F..F; signed max 0x80..0; unsigned min all ones; unsigned max 0 (per SEW lane).
REQ-012 SHALL assert in_ready only in ACCUM with no combine outstanding; one beat per 2 cycles maximum.
REQ-013 SHALL, per accepted beat, drive red_vec0={in_data, acc} with red_en=1 for exactly one cycle next cycle, then capture red_out into acc the following cycle.
REQ-014 SHALL, after the in_last beat, perform F fold steps, F=3,2,1,0 for sew=0..3; step i drives operand B = acc >> (32>>(i-1)) with vacated upper bits filled by identity.
REQ-015 SHALL then perform one scalar step with operand B = latched scalar lane 0 (upper lanes identity), operand A = acc.
REQ-016 SHALL raise out_valid exactly 2*(F+2) cycles after the last-beat handshake, with out_data = acc lane 0 masked to SEW, upper bits 0.
REQ-017 SHALL hold out_valid and out_data stable until out_ready=1, then return to IDLE the next cycle; out_valid&out_ready with start in the same cycle SHALL NOT start a new reduction.
REQ-018 SHALL, on start with start_empty=1, skip ACCUM, fold and scalar steps and present scalar lane 0 masked to SEW on out_valid 2 cycles later.
REQ-019 SHALL drive red_sew and red_opsel from the latched values at all times outside IDLE, and red_en=0 in IDLE, ACCUM-wait and DONE.
REQ-020 SHALL ignore in_valid when in_ready=0; beats after in_last are not consumed.

Reset
REQ-021 SHALL on rst=1, at any time including mid-reduction, immediately force state IDLE, acc 0, out_valid 0, in_ready 0, red_en 0, busy 0, out_data 0.
REQ-022 SHALL discard any outstanding combine result after reset release.

Configuration
REQ-023 SHALL with VRED_SEQ_MINMAX_EN defined support sum, min, max, minu, maxu identities.
REQ-024 SHALL without VRED_SEQ_MINMAX_EN compile out identity selection; acc and fill always 0 and every opSel is treated as sum.

Structure
REQ-025 SHALL place opcode constants (OP_SUM, OP_MIN, OP_MAX, OP_MINU, OP_MAXU), SEW codes, state enum and the identity-value function in a shared package vred_pkg.
REQ-026 SHALL implement the lane shift-and-identity-fill in one sub-module vred_fold_shift; the pairwise combiner remains external.

Verification
REQ-027 SHALL check: sew=2 sum, scalar=5, beats {0x2_00000001, 0x4_00000003} -> out_data=0xF, out_valid 2*(1+2)=6 cycles after last beat.
REQ-028 SHALL check: sew=0 signed min, one beat 0x8107FF0302010005, scalar 0x7F -> out_data=0x81.
REQ-029 SHALL check: sew=3 unsigned max, start_empty=1, scalar 0x1234 -> out_data=0x1234 two cycles after start, red_en never 1.
REQ-030 SHALL check: out_ready held 0 for 10 cycles -> out_valid and out_data stable; start pulses during DONE ignored.
REQ-031 SHALL check: rst asserted during fold step -> all outputs 0 same cycle; next reduction sew=1 sum yields correct result.
REQ-032 SHALL check: build without VRED_SEQ_MINMAX_EN, opSel=min, beat 0x0003_0002, sew=1, scalar 0 -> out_data=0x5.

Source files
------------

// File: rtl/vred_pkg.sv
// vred_pkg: shared definitions for the vector reduction sequencer.
//   - opcode constants (OP_SUM, OP_MIN, OP_MAX, OP_MINU, OP_MAXU)
//   - element-width codes (SEW_8 .. SEW_64)
//   - sequencer state and step-kind enums
//   - helpers: per-SEW lane mask, fold-step count, per-lane identity value
package vred_pkg;

  localparam int unsigned OP_SUM  = 0;
  localparam int unsigned OP_MIN  = 1;
  localparam int unsigned OP_MAX  = 2;
  localparam int unsigned OP_MINU = 3;
  localparam int unsigned OP_MAXU = 4;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ISSUE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    STEP_BEAT,
    STEP_FOLD,
    STEP_SCALAR,
    STEP_EMPTY
  } step_e;

  // Mask covering one element of the given width.
  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Number of halving folds needed to bring all lanes down to lane 0.
  function automatic logic [1:0] fold_count(input logic [1:0] sew);
    return SEW_64 - sew;
  endfunction

  // Identity element of one lane (lane-width bits, zero above).
  function automatic logic [63:0] lane_identity(input int unsigned op, input logic [1:0] sew);
    logic [63:0] m;
    m = sew_mask(sew);
    case (op)
      OP_MIN:  return m >> 1;
      OP_MAX:  return m & ~(m >> 1);
      OP_MINU: return m;
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/vred_fold_shift.sv
// vred_fold_shift: operand-B generator for a fold step.
//   Shifts the accumulator right by DATA_WIDTH >> i_step and fills the
//   vacated upper bits from the replicated identity pattern.
// Ports:
//   i_data  accumulator value to fold
//   i_fill  identity replicated per lane
//   i_step  fold index (1 = half width, 2 = quarter, 3 = eighth)
//   o_data  shifted operand with identity fill
module vred_fold_shift #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_fill,
  input  logic [1:0]            i_step,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_ones;
  logic [DATA_WIDTH-1:0] w_keep;

  always_comb begin
    w_ones = '1;
    w_keep = w_ones >> (DATA_WIDTH >> i_step);
    o_data = (i_data >> (DATA_WIDTH >> i_step)) | (i_fill & ~w_keep);
  end

endmodule

// File: rtl/vred_sequencer.sv
// vred_sequencer: sequences a lane-wise vector reduction through an
// external pairwise combiner (red_vec0/red_en -> red_out one cycle later).
// Flow: accumulate input beats, fold lanes down to lane 0, combine the
// scalar operand, then present lane 0 on out_valid/out_data.
// Configuration macro: VRED_SEQ_MINMAX_EN enables min/max identities;
// without it the accumulator/fill are zero and every opSel acts as sum.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, start_empty, busy request, zero-length flag, not-idle status
//   sew, opSel, scalar       element width, opcode, initial element
//   in_valid/in_ready/in_data/in_last   beat stream
//   red_vec0/red_en/red_sew/red_opsel/red_out  combiner interface
//   out_valid/out_ready/out_data        result handshake
module vred_sequencer
  import vred_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned SEW_WIDTH   = 2,
  parameter int unsigned OPSEL_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    start_empty,
  output logic                    busy,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OPSEL_WIDTH-1:0]  opSel,
  input  logic [DATA_WIDTH-1:0]   scalar,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic [2*DATA_WIDTH-1:0] red_vec0,
  output logic                    red_en,
  output logic [SEW_WIDTH-1:0]    red_sew,
  output logic [OPSEL_WIDTH-1:0]  red_opsel,
  input  logic [DATA_WIDTH-1:0]   red_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data
);

  state_e                  r_state;
  step_e                   r_kind;
  logic [1:0]              r_fold;
  logic [1:0]              r_nfold;
  logic                    r_last;
  logic [SEW_WIDTH-1:0]    r_sew;
  logic [OPSEL_WIDTH-1:0]  r_opsel;
  logic [DATA_WIDTH-1:0]   r_scalar;
  logic [DATA_WIDTH-1:0]   r_fill;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [2*DATA_WIDTH-1:0] r_vec0;
  logic                    r_en;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_busy;

  logic [DATA_WIDTH-1:0]   w_fill_in;
  logic [OPSEL_WIDTH-1:0]  w_opsel_in;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_fold_b;
  logic [DATA_WIDTH-1:0]   w_scalar_b;
  logic [1:0]              w_next_fold;
  logic                    w_more_folds;

`ifdef VRED_SEQ_MINMAX_EN
  logic [63:0] w_lane_id;
  logic [5:0]  w_lidx_mask;

  // Replicate the lane identity across every lane of the beat.
  always_comb begin
    w_lane_id   = lane_identity(32'(opSel), sew[1:0]);
    w_lidx_mask = 6'((32'd8 << sew[1:0]) - 32'd1);
    w_fill_in   = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      w_fill_in[b] = w_lane_id[6'(b) & w_lidx_mask];
    end
  end
  assign w_opsel_in = opSel;
`else
  logic w_unused_opsel;
  assign w_unused_opsel = ^opSel;
  assign w_fill_in      = '0;
  assign w_opsel_in     = OPSEL_WIDTH'(OP_SUM);
`endif

  assign w_mask       = DATA_WIDTH'(sew_mask(r_sew[1:0]));
  assign w_next_fold  = (r_kind == STEP_BEAT) ? 2'd1 : r_fold + 2'd1;
  assign w_more_folds = (r_kind == STEP_BEAT) ? (r_nfold != 2'd0) : (r_fold < r_nfold);
  assign w_scalar_b   = (r_scalar & w_mask) | (r_fill & ~w_mask);

  // Operand B is built from red_out, i.e. the value being captured into acc.
  vred_fold_shift #(.DATA_WIDTH(DATA_WIDTH)) u_fold_shift (
    .i_data (red_out),
    .i_fill (r_fill),
    .i_step (w_next_fold),
    .o_data (w_fold_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_kind      <= STEP_BEAT;
      r_fold      <= '0;
      r_nfold     <= '0;
      r_last      <= 1'b0;
      r_sew       <= '0;
      r_opsel     <= '0;
      r_scalar    <= '0;
      r_fill      <= '0;
      r_acc       <= '0;
      r_vec0      <= '0;
      r_en        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sew    <= sew;
            r_opsel  <= w_opsel_in;
            r_scalar <= scalar;
            r_fill   <= w_fill_in;
            r_acc    <= w_fill_in;
            r_nfold  <= fold_count(sew[1:0]);
            r_busy   <= 1'b1;
            if (start_empty) begin
              // Empty vector passes through the issue/capture slots without
              // a combine so its result appears two cycles after start.
              r_kind  <= STEP_EMPTY;
              r_state <= ST_ISSUE;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_vec0     <= {in_data, r_acc};
            r_en       <= 1'b1;
            r_last     <= in_last;
            r_kind     <= STEP_BEAT;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (r_kind == STEP_EMPTY) begin
            r_out_data  <= r_scalar & w_mask;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_kind == STEP_SCALAR) begin
            r_acc       <= red_out;
            r_out_data  <= red_out & w_mask;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_kind == STEP_BEAT && !r_last) begin
            r_acc      <= red_out;
            r_in_ready <= 1'b1;
            r_state    <= ST_ACCUM;
          end else if (w_more_folds) begin
            r_acc   <= red_out;
            r_kind  <= STEP_FOLD;
            r_fold  <= w_next_fold;
            r_vec0  <= {w_fold_b, red_out};
            r_en    <= 1'b1;
            r_state <= ST_ISSUE;
          end else begin
            r_acc   <= red_out;
            r_kind  <= STEP_SCALAR;
            r_vec0  <= {w_scalar_b, red_out};
            r_en    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign red_vec0  = r_vec0;
  assign red_en    = r_en;
  assign red_sew   = r_sew;
  assign red_opsel = r_opsel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_vred_sequencer.sv
`timescale 1ns/1ps
module tb_vred_sequencer;
  import vred_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_empty, busy;
  logic [1:0]    sew;
  logic [8:0]    opSel;
  logic [63:0]   scalar;
  logic          in_valid, in_ready, in_last;
  logic [63:0]   in_data;
  logic [127:0]  red_vec0;
  logic          red_en;
  logic [1:0]    red_sew;
  logic [8:0]    red_opsel;
  logic [63:0]   red_out;
  logic          out_valid, out_ready;
  logic [63:0]   out_data;

  int unsigned   chk_cnt = 0;
  int unsigned   pass_cnt = 0;
  int unsigned   cyc = 0;
  int unsigned   en_cnt = 0;
  logic [63:0]   sb[$];

  typedef struct {
    logic [1:0]       sew;
    int unsigned      op;
    logic [63:0]      scalar;
    bit               empty;
    int unsigned      nb;
    logic [3:0][63:0] beats;
    logic [63:0]      exp;
    int unsigned      hold;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  vred_sequencer #(.DATA_WIDTH(64), .SEW_WIDTH(2), .OPSEL_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .start_empty(start_empty), .busy(busy),
    .sew(sew), .opSel(opSel), .scalar(scalar),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .red_vec0(red_vec0), .red_en(red_en), .red_sew(red_sew), .red_opsel(red_opsel),
    .red_out(red_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [63:0] elem_op(input logic [63:0] a_in, input logic [63:0] b_in,
                                          input int unsigned w, input int unsigned op);
    logic [63:0] m, sb_, a, b;
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sb_ = 64'd1 << (w - 1);
    a = a_in & m;
    b = b_in & m;
    case (op)
      OP_MIN:  return ((a ^ sb_) < (b ^ sb_)) ? a : b;
      OP_MAX:  return ((a ^ sb_) > (b ^ sb_)) ? a : b;
      OP_MINU: return (a < b) ? a : b;
      OP_MAXU: return (a > b) ? a : b;
      default: return (a + b) & m;
    endcase
  endfunction

  // External lane-wise pairwise combiner (one-cycle latency).
  function automatic logic [63:0] combine(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] s, input int unsigned op);
    int unsigned w;
    logic [63:0] r;
    w = 8 << s;
    r = '0;
    for (int unsigned l = 0; l < 64 / w; l++)
      r = r | (elem_op(a >> (l * w), b >> (l * w), w, op) << (l * w));
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (red_en) begin
      en_cnt  <= en_cnt + 1;
      red_out <= combine(red_vec0[63:0], red_vec0[127:64], red_sew, int'(red_opsel));
    end
  end

  // Flat reference: reduce every element plus the scalar directly.
  function automatic logic [63:0] ref_reduce(input vec_t v);
    int unsigned w, op;
    logic [63:0] r, m;
    w = 8 << v.sew;
`ifdef VRED_SEQ_MINMAX_EN
    op = v.op;
`else
    op = OP_SUM;
`endif
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    r = v.scalar & m;
    if (!v.empty)
      for (int unsigned b = 0; b < v.nb; b++)
        for (int unsigned l = 0; l < 64 / w; l++)
          r = elem_op(r, v.beats[b] >> (l * w), w, op);
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called just after a negedge; returns the posedge index of the start.
  task automatic drive_start(input vec_t v, output int unsigned hs);
    sew = v.sew; opSel = 9'(v.op); scalar = v.scalar;
    start_empty = v.empty; start = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    start = 1'b0; start_empty = 1'b0;
  endtask

  task automatic drive_beats(input vec_t v, input string tag, inout int unsigned hs);
    int unsigned t;
    for (int unsigned b = 0; b < v.nb; b++) begin
      in_valid = 1'b1; in_data = v.beats[b]; in_last = (b == v.nb - 1);
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) check({tag, "_in_ready_timeout"}, in_ready, 1);
      hs = cyc + 1;
      @(negedge clk);
      // Beats offered after the last one must not be consumed.
      in_data = 64'hDEAD_BEEF_DEAD_BEEF; in_last = 1'b0;
      in_valid = (b == v.nb - 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned hs, t, en0, unstable, f, lat;
    logic [63:0] held, exp;
    f = 3 - v.sew;
    lat = v.empty ? 2 : 2 * (f + 2);
    sb.push_back(v.exp);
    en0 = en_cnt;
    drive_start(v, hs);
    if (!v.empty) drive_beats(v, tag, hs);
    t = 0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    check({tag, "_latency"}, cyc - hs, lat);
    held = out_data; unstable = 0;
    for (int unsigned i = 0; i < v.hold; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      if (!out_valid || out_data !== held || !busy) unstable++;
    end
    if (v.hold > 0) check({tag, "_hold_stable"}, unstable, 0);
    out_ready = 1'b1;
    start = (v.hold > 0);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
    check({tag, "_result"}, out_data, exp);
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    check({tag, "_idle_after"}, {busy, out_valid, in_ready}, 3'b000);
    check({tag, "_red_en_count"}, en_cnt - en0, v.empty ? 0 : v.nb + f + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int unsigned hs;
    rst = 1'b1; start = 0; start_empty = 0; sew = 0; opSel = 0; scalar = 0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;

    tbl[0] = '{sew:2'd2, op:OP_SUM, scalar:64'd5, empty:0, nb:2,
               beats:{64'd0, 64'd0, 64'h4_0000_0003, 64'h2_0000_0001}, exp:64'hF, hold:0};
`ifdef VRED_SEQ_MINMAX_EN
    tbl[1] = '{sew:2'd0, op:OP_MIN, scalar:64'h7F, empty:0, nb:1,
               beats:{64'd0, 64'd0, 64'd0, 64'h8107_FF03_0201_0005}, exp:64'h81, hold:0};
    tbl[3] = '{sew:2'd1, op:OP_MIN, scalar:64'd0, empty:0, nb:1,
               beats:{64'd0, 64'd0, 64'd0, 64'h0003_0002}, exp:64'h0, hold:0};
`else
    tbl[1] = '{sew:2'd0, op:OP_MIN, scalar:64'h7F, empty:0, nb:1,
               beats:{64'd0, 64'd0, 64'd0, 64'h8107_FF03_0201_0005}, exp:64'h11, hold:0};
    tbl[3] = '{sew:2'd1, op:OP_MIN, scalar:64'd0, empty:0, nb:1,
               beats:{64'd0, 64'd0, 64'd0, 64'h0003_0002}, exp:64'h5, hold:0};
`endif
    tbl[2] = '{sew:2'd3, op:OP_MAXU, scalar:64'h1234, empty:1, nb:0,
               beats:{64'd0, 64'd0, 64'd0, 64'd0}, exp:64'h1234, hold:10};
    tbl[4] = '{sew:2'd1, op:OP_SUM, scalar:64'h10, empty:0, nb:2,
               beats:{64'd0, 64'd0, 64'hFFFF_0001_0001_0001, 64'h0001_0002_0003_0004},
               exp:64'h1C, hold:0};
    for (int unsigned i = 5; i < 9; i++) begin
      tbl[i].sew    = (i == 5) ? 2'd0 : (i == 6) ? 2'd2 : (i == 7) ? 2'd3 : 2'd0;
      tbl[i].op     = (i == 5) ? OP_SUM : (i == 6) ? OP_MAXU : (i == 7) ? OP_MAX : OP_MINU;
      tbl[i].scalar = {$urandom, $urandom};
      tbl[i].empty  = 0;
      tbl[i].nb     = (i == 8) ? 4 : (i == 5) ? 3 : 2;
      for (int unsigned b = 0; b < 4; b++) tbl[i].beats[b] = {$urandom, $urandom};
      tbl[i].exp    = ref_reduce(tbl[i]);
      tbl[i].hold   = (i == 7) ? 3 : 0;
    end

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, in_ready, out_valid, red_en, out_data, red_vec0, red_sew, red_opsel}, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int unsigned i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset while a fold step is on the combiner interface.
    v = tbl[5]; v.nb = 1;
    drive_start(v, hs);
    drive_beats(v, "rstfold", hs);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstfold_fold_issue", {red_en, busy}, 2'b11);
    #2 rst = 1'b1;
    #1 check("rstfold_outputs", {busy, in_ready, out_valid, red_en, out_data, red_vec0, red_sew, red_opsel}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(tbl[4], "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
